trap_sequencer: RTL and testbench

- Control FSM behind the writeback stage. It turns writeback's trap, mret and wfi indications into pipeline flushes, a fetch redirect and CSR update strobes.
- Holds fetch in a low-power sleep state for WFI until an interrupt is pending.
- Sits between writeback, the CSR file and fetch, and owns every front-end redirect that is not a branch.

---
 rtl/trap_sequencer_pkg.sv | 19 +
 rtl/trap_target_calc.sv | 23 ++
 rtl/trap_sequencer.sv | 156 +++++++++++++++
 tb/tb_trap_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the trap sequencer.
// FSM state encoding, interrupt cause codes and mtvec mode values.
package trap_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        SLEEP = 2'd3
    } seq_state_t;

    localparam logic [3:0] CAUSE_SW_IRQ    = 4'd3;
    localparam logic [3:0] CAUSE_TIMER_IRQ = 4'd7;
    localparam logic [3:0] CAUSE_EXT_IRQ   = 4'd11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_target_calc.sv
// Redirect target selection for traps and MRET.
// Vectored mode offsets only interrupts, by 4*cause.
import trap_sequencer_pkg::*;

module trap_target_calc (
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic [3:0]  ecause,
    input  logic        interrupt,
    input  logic        sel_mret,
    output logic [31:0] target
);

    logic [31:0] base;
    logic [31:0] offset;
    logic        direct;

    assign base   = {mtvec[31:2], 2'b00};
    assign direct = (mtvec[1:0] == MTVEC_DIRECT) || !interrupt;
    assign offset = direct ? 32'd0 : {26'd0, ecause, 2'b00};
    assign target = sel_mret ? mepc : base + offset;

endmodule

// File: rtl/trap_sequencer.sv
// Writeback-side control FSM: flushes, non-branch redirects, CSR strobes.
// Define TRAP_SEQ_SLEEP_EN to build the WFI sleep state.
import trap_sequencer_pkg::*;

module trap_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_trap,
    input  logic        wb_retired,
    input  logic        wb_mret,
    input  logic        wb_wfi,
    input  logic [3:0]  wb_ecause,
    input  logic        wb_interrupt,
    input  logic [31:0] wb_ecp,
    input  logic [31:0] wb_next_pc,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        irq_pending,
    output logic        flush,
    output logic        sleep,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        csr_trap_we,
    output logic [3:0]  csr_ecause,
    output logic        csr_interrupt,
    output logic [31:0] csr_ecp,
    output logic        csr_mret_we,
    output logic        busy
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    seq_state_t  state;
    logic [3:0]  cnt;
    logic        flush_q;
    logic        mret_ev;
    logic        wfi_ev;
    logic        run_ev;
    logic [31:0] target;

    assign mret_ev = wb_retired & wb_mret & ~wb_trap;
`ifdef TRAP_SEQ_SLEEP_EN
    logic [31:0] next_pc_q;
    assign wfi_ev = wb_retired & wb_wfi & ~wb_trap & ~wb_mret;
`else
    logic unused_ok;
    assign unused_ok = ^{wb_wfi, wb_next_pc, irq_pending};
    assign wfi_ev    = 1'b0;
    assign sleep     = 1'b0;
`endif

    // Trigger-cycle flush is combinational so the younger stages die now.
    assign run_ev = (state == RUN) & (wb_trap | mret_ev | wfi_ev);
    assign flush  = flush_q | run_ev;

    trap_target_calc u_target (
        .mtvec     (mtvec),
        .mepc      (mepc),
        .ecause    (wb_ecause),
        .interrupt (wb_interrupt),
        .sel_mret  (!wb_trap),
        .target    (target)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= BOOT;
            cnt            <= 4'd0;
            flush_q        <= 1'b0;
            busy           <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            csr_trap_we    <= 1'b0;
            csr_ecause     <= 4'd0;
            csr_interrupt  <= 1'b0;
            csr_ecp        <= 32'd0;
            csr_mret_we    <= 1'b0;
`ifdef TRAP_SEQ_SLEEP_EN
            sleep          <= 1'b0;
            next_pc_q      <= 32'd0;
`endif
        end else begin
            redirect_valid <= 1'b0;
            csr_trap_we    <= 1'b0;
            csr_mret_we    <= 1'b0;
            unique case (state)
                BOOT: begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= RESET_PC;
                    state          <= DRAIN;
                    cnt            <= DRAIN_LOAD;
                    flush_q        <= 1'b1;
                    busy           <= 1'b1;
                end
                RUN: begin
                    if (wb_trap) begin
                        csr_trap_we    <= 1'b1;
                        csr_ecause     <= wb_ecause;
                        csr_interrupt  <= wb_interrupt;
                        csr_ecp        <= wb_ecp;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= target;
                        state          <= DRAIN;
                        cnt            <= DRAIN_LOAD;
                        flush_q        <= 1'b1;
                        busy           <= 1'b1;
                    end else if (mret_ev) begin
                        csr_mret_we    <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= target;
                        state          <= DRAIN;
                        cnt            <= DRAIN_LOAD;
                        flush_q        <= 1'b1;
                        busy           <= 1'b1;
                    end
`ifdef TRAP_SEQ_SLEEP_EN
                    else if (wfi_ev) begin
                        next_pc_q <= wb_next_pc;
                        state     <= SLEEP;
                        sleep     <= 1'b1;
                        flush_q   <= 1'b1;
                        busy      <= 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (cnt == 4'd0) begin
                        state   <= RUN;
                        flush_q <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`ifdef TRAP_SEQ_SLEEP_EN
                SLEEP: begin
                    if (irq_pending) begin
                        sleep          <= 1'b0;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= next_pc_q;
                        state          <= DRAIN;
                        cnt            <= DRAIN_LOAD;
                    end
                end
`endif
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer.
// Expectations follow the TRAP_SEQ_SLEEP_EN build selection.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_trap, wb_retired, wb_mret, wb_wfi;
    logic [3:0]  wb_ecause;
    logic        wb_interrupt;
    logic [31:0] wb_ecp, wb_next_pc, mtvec, mepc;
    logic        irq_pending;
    logic        flush, sleep, redirect_valid;
    logic [31:0] redirect_pc;
    logic        csr_trap_we;
    logic [3:0]  csr_ecause;
    logic        csr_interrupt;
    logic [31:0] csr_ecp;
    logic        csr_mret_we, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trap_sequencer #(
        .DRAIN_CYCLES (3),
        .RESET_PC     (32'h100)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wb_trap        (wb_trap),
        .wb_retired     (wb_retired),
        .wb_mret        (wb_mret),
        .wb_wfi         (wb_wfi),
        .wb_ecause      (wb_ecause),
        .wb_interrupt   (wb_interrupt),
        .wb_ecp         (wb_ecp),
        .wb_next_pc     (wb_next_pc),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .irq_pending    (irq_pending),
        .flush          (flush),
        .sleep          (sleep),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .csr_trap_we    (csr_trap_we),
        .csr_ecause     (csr_ecause),
        .csr_interrupt  (csr_interrupt),
        .csr_ecp        (csr_ecp),
        .csr_mret_we    (csr_mret_we),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_trap = 0; wb_retired = 0; wb_mret = 0; wb_wfi = 0;
        wb_ecause = 0; wb_interrupt = 0; wb_ecp = 0;
        wb_next_pc = 0; irq_pending = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flush"}, {31'd0, flush}, 0);
        chk({tag, "_sleep"}, {31'd0, sleep}, 0);
        chk({tag, "_rv"}, {31'd0, redirect_valid}, 0);
        chk({tag, "_pc"}, redirect_pc, 0);
        chk({tag, "_twe"}, {31'd0, csr_trap_we}, 0);
        chk({tag, "_mwe"}, {31'd0, csr_mret_we}, 0);
        chk({tag, "_ecp"}, csr_ecp, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    initial begin
        int sleep_cnt;
        reset_n = 0;
        mtvec = 0; mepc = 0;
        idle_inputs();
        tick(); tick();
        chk_all_zero("reset");

        // Boot: redirect to RESET_PC, flush for three cycles.
        reset_n = 1;
        tick();
        chk("boot_rv", {31'd0, redirect_valid}, 1);
        chk("boot_pc", redirect_pc, 32'h100);
        chk("boot_flush1", {31'd0, flush}, 1);
        chk("boot_busy", {31'd0, busy}, 1);
        tick();
        chk("boot_rv_pulse", {31'd0, redirect_valid}, 0);
        chk("boot_flush2", {31'd0, flush}, 1);
        tick();
        chk("boot_flush3", {31'd0, flush}, 1);
        tick();
        chk("boot_flush_done", {31'd0, flush}, 0);
        chk("boot_idle", {31'd0, busy}, 0);

        // Exception, direct target despite vectored mtvec.
        wb_trap = 1; wb_ecause = 2; wb_interrupt = 0;
        wb_ecp = 32'h2000; mtvec = 32'h8001;
        #1;
        chk("exc_flush_comb", {31'd0, flush}, 1);
        tick();
        idle_inputs();
        chk("exc_twe", {31'd0, csr_trap_we}, 1);
        chk("exc_ecp", csr_ecp, 32'h2000);
        chk("exc_cause", {28'd0, csr_ecause}, 2);
        chk("exc_int", {31'd0, csr_interrupt}, 0);
        chk("exc_rv", {31'd0, redirect_valid}, 1);
        chk("exc_pc", redirect_pc, 32'h8000);
        tick();
        chk("exc_twe_pulse", {31'd0, csr_trap_we}, 0);
        tick(); tick();
        chk("exc_run", {31'd0, busy}, 0);

        // Vectored interrupt; trap held high through DRAIN is ignored.
        wb_trap = 1; wb_ecause = 7; wb_interrupt = 1;
        wb_ecp = 32'h2040; mtvec = 32'h8001;
        tick();
        chk("vec_pc", redirect_pc, 32'h801C);
        chk("vec_int", {31'd0, csr_interrupt}, 1);
        chk("vec_cause", {28'd0, csr_ecause}, 7);
        tick();
        chk("vec_drain_twe", {31'd0, csr_trap_we}, 0);
        chk("vec_drain_rv", {31'd0, redirect_valid}, 0);
        tick();
        idle_inputs();
        tick();
        chk("vec_run", {31'd0, busy}, 0);
        chk("vec_run_flush", {31'd0, flush}, 0);

        // MRET without retire is not an event.
        wb_mret = 1; wb_retired = 0; mepc = 32'h3004;
        #1;
        chk("mret_noret_flush", {31'd0, flush}, 0);
        tick();
        chk("mret_noret_mwe", {31'd0, csr_mret_we}, 0);

        // MRET.
        wb_retired = 1;
        #1;
        chk("mret_flush_comb", {31'd0, flush}, 1);
        tick();
        idle_inputs();
        chk("mret_mwe", {31'd0, csr_mret_we}, 1);
        chk("mret_twe", {31'd0, csr_trap_we}, 0);
        chk("mret_rv", {31'd0, redirect_valid}, 1);
        chk("mret_pc", redirect_pc, 32'h3004);
        tick();
        chk("mret_mwe_pulse", {31'd0, csr_mret_we}, 0);
        tick(); tick();
        chk("mret_run", {31'd0, busy}, 0);

        // Trap and MRET together: trap wins.
        wb_trap = 1; wb_mret = 1; wb_retired = 1;
        wb_ecause = 11; wb_interrupt = 1; wb_ecp = 32'h5000;
        mtvec = 32'h8000;
        tick();
        idle_inputs();
        chk("both_twe", {31'd0, csr_trap_we}, 1);
        chk("both_mwe", {31'd0, csr_mret_we}, 0);
        chk("both_pc", redirect_pc, 32'h8000);
        tick(); tick(); tick();
        chk("both_run", {31'd0, busy}, 0);

`ifdef TRAP_SEQ_SLEEP_EN
        // WFI, interrupt arrives ten cycles later.
        wb_wfi = 1; wb_retired = 1; wb_next_pc = 32'h400;
        #1;
        chk("wfi_flush_comb", {31'd0, flush}, 1);
        tick();
        idle_inputs();
        chk("wfi_rv", {31'd0, redirect_valid}, 0);
        chk("wfi_busy", {31'd0, busy}, 1);
        sleep_cnt = int'(sleep);
        for (int i = 0; i < 9; i++) begin
            tick();
            sleep_cnt += int'(sleep);
        end
        irq_pending = 1;
        tick();
        chk("wfi_sleep_len", sleep_cnt, 10);
        chk("wfi_wake_sleep", {31'd0, sleep}, 0);
        chk("wfi_wake_rv", {31'd0, redirect_valid}, 1);
        chk("wfi_wake_pc", redirect_pc, 32'h400);
        irq_pending = 0;
        tick(); tick(); tick();
        chk("wfi_run", {31'd0, busy}, 0);

        // Interrupt already pending: one sleep cycle.
        wb_wfi = 1; wb_retired = 1; wb_next_pc = 32'h480;
        irq_pending = 1;
        tick();
        wb_wfi = 0; wb_retired = 0;
        chk("wfi1_sleep", {31'd0, sleep}, 1);
        tick();
        chk("wfi1_wake", {31'd0, sleep}, 0);
        chk("wfi1_pc", redirect_pc, 32'h480);
        irq_pending = 0;
        tick(); tick(); tick();

        // Reset while asleep.
        wb_wfi = 1; wb_retired = 1; wb_next_pc = 32'h500;
        tick();
        idle_inputs();
        tick();
        chk("rst_pre_sleep", {31'd0, sleep}, 1);
`else
        // WFI retires as a NOP.
        wb_wfi = 1; wb_retired = 1; wb_next_pc = 32'h400;
        #1;
        chk("wfi_nop_flush", {31'd0, flush}, 0);
        tick();
        idle_inputs();
        chk("wfi_nop_sleep", {31'd0, sleep}, 0);
        chk("wfi_nop_busy", {31'd0, busy}, 0);
        chk("wfi_nop_rv", {31'd0, redirect_valid}, 0);

        // Reset in the middle of DRAIN.
        wb_trap = 1; wb_ecause = 2; wb_ecp = 32'h2000;
        tick();
        idle_inputs();
        tick();
        chk("rst_pre_busy", {31'd0, busy}, 1);
`endif
        #2;
        reset_n = 0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        chk("rst_hold_busy", {31'd0, busy}, 0);
        reset_n = 1;
        tick();
        chk("reboot_rv", {31'd0, redirect_valid}, 1);
        chk("reboot_pc", redirect_pc, 32'h100);
        chk("reboot_twe", {31'd0, csr_trap_we}, 0);
        tick(); tick(); tick();
        chk("reboot_run", {31'd0, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
